// File: rtl/booth_div_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
package booth_div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

    // Counter width: must hold values 0..n for n+1 quotient steps.
    function automatic int div_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/booth_divider_n_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step_n #(
    parameter int N = 8
) (
    input  logic [N+1:0] rem,
    input  logic         din_bit,
    input  logic [N:0]   b_mag,
    output logic [N+1:0] rem_nxt,
    output logic         q_bit
);

    logic [N+2:0] shifted;
    logic [N+2:0] b_ext;

    always_comb begin
        shifted = {rem, din_bit};
        b_ext   = (N+3)'(b_mag);
        q_bit   = (shifted >= b_ext);
        // rem stays below |b| <= 2^N, so the result always fits N+2 bits.
        rem_nxt = (N+2)'(q_bit ? (shifted - b_ext) : shifted);
    end

endmodule

// File: rtl/booth_divider_n.sv
// Sequential signed divider: restoring shift-subtract on magnitudes plus sign fix-up.
// Optional BOOTH_DIV_DBZ_EN adds dbz_o and an early exit for a zero divisor.
module booth_divider_n
    import booth_div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [N:0] data0_i,
    input  logic [N:0] data1_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [N:0] q_o,
    output logic [N:0] r_o
`ifdef BOOTH_DIV_DBZ_EN
    ,
    output logic       dbz_o
`endif
);

    localparam int CW = div_cnt_w(N);

    div_state_t     state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [N+1:0]   rem;
    logic [N:0]     quo;
    logic [N:0]     b_mag;
    logic [N:0]     a_lat;
    logic           sa, sb, bz;

    logic           accept;
    logic           early_exit;
    logic [N:0]     a_mag_in, b_mag_in;
    logic [N+1:0]   step_rem;
    logic           step_q;

    div_step_n #(.N(N)) u_step (
        .rem     (rem),
        .din_bit (quo[N]),
        .b_mag   (b_mag),
        .rem_nxt (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        accept   = start_i && ((state == IDLE) || (state == DONE));
        // Unsigned N+1-bit magnitude: -2^N maps onto 2^N without an extra bit.
        a_mag_in = data0_i[N] ? -data0_i : data0_i;
        b_mag_in = data1_i[N] ? -data1_i : data1_i;
`ifdef BOOTH_DIV_DBZ_EN
        early_exit = (data1_i == '0);
`else
        early_exit = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE, DONE: begin
                done_o = (state == DONE);
                if (accept) state_nxt = early_exit ? DONE : CALC;
                else        state_nxt = IDLE;
            end
            CALC: begin
                busy_o = 1'b1;
                if (cnt == CW'(N)) state_nxt = FIX;
            end
            FIX: begin
                busy_o    = 1'b1;
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            b_mag <= '0;
            a_lat <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            bz    <= 1'b0;
            q_o   <= '0;
            r_o   <= '0;
`ifdef BOOTH_DIV_DBZ_EN
            dbz_o <= 1'b0;
`endif
        end else if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= a_mag_in;
            b_mag <= b_mag_in;
            a_lat <= data0_i;
            sa    <= data0_i[N];
            sb    <= data1_i[N];
            bz    <= (data1_i == '0);
`ifdef BOOTH_DIV_DBZ_EN
            if (early_exit) begin
                q_o   <= '1;
                r_o   <= data0_i;
                dbz_o <= 1'b1;
            end
`endif
        end else if (state == CALC) begin
            rem <= step_rem;
            quo <= {quo[N-1:0], step_q};
            cnt <= cnt + CW'(1);
        end else if (state == FIX) begin
            if (bz) begin
                q_o <= '1;
                r_o <= a_lat;
            end else begin
                q_o <= (sa ^ sb) ? -quo : quo;
                r_o <= sa ? -rem[N:0] : rem[N:0];
            end
`ifdef BOOTH_DIV_DBZ_EN
            dbz_o <= bz;
`endif
        end
    end

endmodule

// File: tb/tb_booth_divider_n.sv
// Scoreboard bench for booth_divider_n; honours BOOTH_DIV_DBZ_EN when defined.
module tb_booth_divider_n;

    localparam int N = 8;
    localparam int W = N + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           cyc;
        int           busy;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data0 = '0;
    logic [W-1:0] data1 = '0;
    logic         busy, done;
    logic [W-1:0] q, r;
`ifdef BOOTH_DIV_DBZ_EN
    logic         dbz;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_run = 0;
    exp_t sb[$];

    booth_divider_n #(.N(N)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .data0_i (data0),
        .data1_i (data1),
        .busy_o  (busy),
        .done_o  (done),
        .q_o     (q),
        .r_o     (r)
`ifdef BOOTH_DIV_DBZ_EN
        ,
        .dbz_o   (dbz)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: plain signed arithmetic, truncated to the operand width.
    function automatic exp_t model(input logic [W-1:0] a_bits, input logic [W-1:0] b_bits, input int c);
        exp_t e;
        logic signed [W-1:0] sa_v, sb_v;
        int a, b, qi, ri;
        sa_v = a_bits;
        sb_v = b_bits;
        a = sa_v;
        b = sb_v;
        if (b == 0) begin
            qi = -1;
            ri = a;
        end else begin
            qi = a / b;
            ri = a % b;
        end
        e.q    = W'(qi);
        e.r    = W'(ri);
        e.dbz  = (b == 0);
        e.cyc  = c + 1 + N + 2;
        e.busy = N + 2;
`ifdef BOOTH_DIV_DBZ_EN
        if (b == 0) begin
            e.cyc  = c + 1;
            e.busy = 0;
        end
`endif
        return e;
    endfunction

    // Monitor: every done pulse retires exactly one expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("q", int'(q), int'(e.q));
                chk("r", int'(r), int'(e.r));
                chk("latency", cyc, e.cyc);
                chk("busy_cycles", busy_run, e.busy);
`ifdef BOOTH_DIV_DBZ_EN
                chk("dbz", int'(dbz), int'(e.dbz));
`endif
            end
        end
        if (busy) busy_run++;
        else      busy_run = 0;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        int guard = 0;
        start = 1'b1;
        data0 = a;
        data1 = b;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) chk("accept_timeout", 1, 0);
        sb.push_back(model(a, b, cyc));
        @(negedge clk);
        // Optionally keep start asserted with junk operands while busy.
        while (hold && busy) begin
            data0 = W'($urandom);
            data1 = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] da [14];
        logic [W-1:0] db [14];
        da = '{W'(100), W'(-100), W'(100), W'(-100), W'(-256), W'(255), W'(0), W'(37),
               W'(-37), W'(255), W'(-256), W'(7), W'(-1), W'(1)};
        db = '{W'(7), W'(7), W'(-7), W'(-7), W'(-1), W'(255), W'(5), W'(0),
               W'(0), W'(-256), W'(1), W'(100), W'(3), W'(-256)};

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_r", int'(r), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            issue(da[i], db[i], 1'b0);
            drain();
        end

        issue(W'(100), W'(7), 1'b1);
        drain();

        // Back-to-back: next request is accepted in the DONE cycle.
        issue(W'(50), W'(-3), 1'b0);
        issue(W'(-77), W'(9), 1'b0);
        issue(W'(37), W'(0), 1'b0);
        issue(W'(12), W'(4), 1'b0);
        drain();

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 4));
                2:       b = W'(-int'($urandom_range(1, 4)));
                default: b = W'($urandom);
            endcase
            issue(a, b, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        issue(W'(123), W'(4), 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_q", int'(q), 0);
        chk("midrst_r", int'(r), 0);
`ifdef BOOTH_DIV_DBZ_EN
        chk("midrst_dbz", int'(dbz), 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle_busy", int'(busy), 0);
        issue(W'(50), W'(5), 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
